// File: rtl/rgb_stream_sequencer_if.sv
// Memory-read and byte-stream signals of the RGB stream sequencer.
// master = sequencer side, slave = memories/consumer side.
interface rgb_stream_sequencer_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_en;
  logic [7:0]        rd_data_r;
  logic [7:0]        rd_data_g;
  logic [7:0]        rd_data_b;
  logic [7:0]        out_data;
  logic [1:0]        out_chan;
  logic              out_valid;
  logic              out_ready;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output rd_addr, rd_en,
    input  rd_data_r, rd_data_g, rd_data_b,
    output out_data, out_chan, out_valid, sof, eol, eof,
    input  out_ready
  );

  modport slave (
    input  rd_addr, rd_en,
    output rd_data_r, rd_data_g, rd_data_b,
    input  out_data, out_chan, out_valid, sof, eol, eof,
    output out_ready
  );
endinterface

// File: rtl/rgb_stream_sequencer.sv
// Walks the R/G/B pixel memories in raster order and emits one byte per
// channel on a valid/ready stream with sof/eol/eof frame markers.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | rd_en strobe for current channel at addr
// LAT   | memory latency; capture byte and markers at end of cycle
// SEND  | out_valid held until out_ready handshake
// DONE  | one-cycle done pulse
module rgb_stream_sequencer #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 48,
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  rgb_stream_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done
);
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LAT, S_SEND, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        chan_q, chan_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [1:0]        out_chan_q, out_chan_d;
  logic              sof_q, sof_d;
  logic              eol_q, eol_d;
  logic              eof_q, eof_d;

  logic              col_last;
  logic              last_pix;
  logic [7:0]        rd_sel;

  assign col_last = (col_q == COL_LAST);
  assign last_pix = col_last && (row_q == ROW_LAST);

  always_comb begin
    case (chan_q)
      2'd0:    rd_sel = bus.rd_data_r;
      2'd1:    rd_sel = bus.rd_data_g;
      default: rd_sel = bus.rd_data_b;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    chan_d     = chan_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    sof_d      = sof_q;
    eol_d      = eol_q;
    eof_d      = eof_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          chan_d  = 2'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: state_d = S_LAT;
      S_LAT: begin
        out_data_d = rd_sel;
        out_chan_d = chan_q;
        sof_d      = (addr_q == '0) && (chan_q == 2'd0);
        eol_d      = col_last && (chan_q == 2'd2);
        eof_d      = last_pix && (chan_q == 2'd2);
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (chan_q != 2'd2) begin
            chan_d  = chan_q + 2'd1;
            state_d = S_REQ;
          end else if (last_pix) begin
            state_d = S_DONE;
          end else begin
            chan_d  = 2'd0;
            addr_d  = addr_q + ADDR_W'(1);
            if (col_last) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
            state_d = S_REQ;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      chan_q     <= 2'd0;
      out_data_q <= 8'd0;
      out_chan_q <= 2'd0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      chan_q     <= chan_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
    end
  end

  // All outputs decode from registers only, so out_ready never reaches them.
  assign bus.rd_addr   = addr_q;
  assign bus.rd_en     = (state_q == S_REQ) ? (3'b001 << chan_q) : 3'b000;
  assign bus.out_valid = (state_q == S_SEND);
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.sof       = sof_q && bus.out_valid;
  assign bus.eol       = eol_q && bus.out_valid;
  assign bus.eof       = eof_q && bus.out_valid;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_rgb_stream_sequencer.sv
// Directed bench: 4x2 frame with backpressure, ignored starts, mid-frame
// reset and replay, plus a separate 1x1 instance.
module tb_rgb_stream_sequencer;
  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic busy_a, done_a, busy_b, done_b;

  int n_checks = 0;
  int n_errors = 0;

  rgb_stream_sequencer_if #(.ADDR_W(4)) bus_a ();
  rgb_stream_sequencer_if #(.ADDR_W(1)) bus_b ();

  rgb_stream_sequencer #(.IMG_W(4), .IMG_H(2), .ADDR_W(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(bus_a), .busy(busy_a), .done(done_a)
  );

  rgb_stream_sequencer #(.IMG_W(1), .IMG_H(1), .ADDR_W(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(bus_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Synchronous memories: data one cycle after rd_en, garbage otherwise.
  always @(posedge clk) begin
    bus_a.rd_data_r <= bus_a.rd_en[0] ? (8'h00 + 8'(bus_a.rd_addr)) : 8'hEE;
    bus_a.rd_data_g <= bus_a.rd_en[1] ? (8'h40 + 8'(bus_a.rd_addr)) : 8'hEE;
    bus_a.rd_data_b <= bus_a.rd_en[2] ? (8'h80 + 8'(bus_a.rd_addr)) : 8'hEE;
    bus_b.rd_data_r <= bus_b.rd_en[0] ? 8'h11 : 8'hEE;
    bus_b.rd_data_g <= bus_b.rd_en[1] ? 8'h22 : 8'hEE;
    bus_b.rd_data_b <= bus_b.rd_en[2] ? 8'h33 : 8'hEE;
  end

  logic [12:0] byte_q[$];
  logic [6:0]  req_q[$];
  logic [12:0] byte_b[$];
  int done_cnt = 0, done_b_cnt = 0;
  int cyc = 0, first_req_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus_a.out_valid && bus_a.out_ready)
        byte_q.push_back({bus_a.eof, bus_a.eol, bus_a.sof, bus_a.out_chan, bus_a.out_data});
      if (bus_a.rd_en != 3'b000) begin
        if (req_q.size() == 0) first_req_cyc = cyc;
        req_q.push_back({bus_a.rd_en, bus_a.rd_addr});
      end
      if (done_a) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus_b.out_valid && bus_b.out_ready)
        byte_b.push_back({bus_b.eof, bus_b.eol, bus_b.sof, bus_b.out_chan, bus_b.out_data});
      if (done_b) done_b_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic check_stream(input string tag, input int n_bytes);
    logic [12:0] exp_b;
    logic [6:0]  exp_r;
    logic [7:0]  p8;
    logic [1:0]  ch;
    check({tag, "_nbytes"}, byte_q.size(), n_bytes);
    check({tag, "_nreq"}, req_q.size(), n_bytes);
    for (int i = 0; i < n_bytes; i++) begin
      p8 = 8'(i / 3);
      ch = 2'(i % 3);
      exp_b = {(i == 23), (ch == 2'd2 && p8[1:0] == 2'd3), (i == 0), ch, 8'(ch * 8'h40 + p8)};
      exp_r = {3'(3'b001 << ch), p8[3:0]};
      if (i < byte_q.size()) check($sformatf("%s_byte%0d", tag, i), byte_q[i], exp_b);
      if (i < req_q.size())  check($sformatf("%s_req%0d", tag, i), req_q[i], exp_r);
    end
  endtask

  task automatic run_frame(input string tag, input bit do_bp, input bit do_spam);
    bit got_done = 0;
    bit stalled  = 0;
    int n = 0;
    byte_q.delete();
    req_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    check({tag, "_req_rd_en"}, bus_a.rd_en, 3'b001);
    check({tag, "_req_addr"}, bus_a.rd_addr, 4'd0);
    check({tag, "_req_busy"}, busy_a, 1'b1);
    @(negedge clk);
    check({tag, "_lat_rd_en"}, bus_a.rd_en, 3'b000);
    check({tag, "_lat_valid"}, bus_a.out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_first_valid"}, bus_a.out_valid, 1'b1);
    check({tag, "_first_data"}, bus_a.out_data, 8'h00);
    check({tag, "_first_sof"}, bus_a.sof, 1'b1);
    while (!got_done && n < 400) begin
      @(posedge clk); #1;
      n++;
      start_a = 1'b0;
      if (done_a) begin
        got_done = 1'b1;
        if (do_spam) start_a = 1'b1;
      end else begin
        if (do_spam && n == 20) start_a = 1'b1;
        if (do_bp && !stalled && bus_a.out_valid && bus_a.out_chan == 2'd1
            && bus_a.out_data == 8'h42) begin
          stalled = 1'b1;
          bus_a.out_ready = 1'b0;
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_data%0d", k), bus_a.out_data, 8'h42);
            check($sformatf("bp_chan%0d", k), bus_a.out_chan, 2'd1);
            check($sformatf("bp_valid%0d", k), bus_a.out_valid, 1'b1);
            check($sformatf("bp_rd_en%0d", k), bus_a.rd_en, 3'b000);
            @(posedge clk); #1;
            n++;
          end
          bus_a.out_ready = 1'b1;
        end
      end
    end
    check({tag, "_done_seen"}, got_done, 1'b1);
    if (do_bp) check({tag, "_bp_hit"}, stalled, 1'b1);
    @(posedge clk); #1 start_a = 1'b0;
    check({tag, "_busy_after_done"}, busy_a, 1'b0);
    check({tag, "_done_pulse_len"}, done_a, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, busy_a, 1'b0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_frame_cycles"}, done_cyc - first_req_cyc, do_bp ? 77 : 72);
    check_stream(tag, 24);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    #12;
    check("rst_rd_addr", bus_a.rd_addr, 4'd0);
    check("rst_rd_en", bus_a.rd_en, 3'b000);
    check("rst_out_data", bus_a.out_data, 8'd0);
    check("rst_out_chan", bus_a.out_chan, 2'd0);
    check("rst_markers", {bus_a.sof, bus_a.eol, bus_a.eof}, 3'b000);
    check("rst_valid", bus_a.out_valid, 1'b0);
    check("rst_busy_done", {busy_a, done_a}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;

    run_frame("fa", 1'b1, 1'b1);
    run_frame("fb", 1'b0, 1'b0);

    // Abort after 10 accepted bytes with rst asserted between clock edges.
    byte_q.delete();
    req_q.delete();
    done_cnt = 0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    n = 0;
    while (byte_q.size() < 10 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("abort_nbytes", byte_q.size(), 10);
    check("abort_valid", bus_a.out_valid, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_rd_en", bus_a.rd_en, 3'b000);
    check("abort_rd_addr", bus_a.rd_addr, 4'd0);
    check("abort_out_data", bus_a.out_data, 8'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_idle", busy_a, 1'b0);

    run_frame("fc", 1'b0, 1'b0);

    // 1x1 frame on the second instance.
    byte_b.delete();
    done_b_cnt = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    n = 0;
    while (done_b_cnt == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("w1_done_cnt", done_b_cnt, 1);
    check("w1_nbytes", byte_b.size(), 3);
    if (byte_b.size() == 3) begin
      check("w1_byte0", byte_b[0], {3'b001, 2'd0, 8'h11});
      check("w1_byte1", byte_b[1], {3'b000, 2'd1, 8'h22});
      check("w1_byte2", byte_b[2], {3'b110, 2'd2, 8'h33});
    end
    @(posedge clk); #1;
    check("w1_busy_after", busy_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rgb_stream_sequencer.md
# rgb_stream_sequencer

Sequences the three per-channel pixel memories (R, G, B) into one 8-bit serial stream in R,G,B byte order per pixel, raster order per frame. It sits between the channel ROMs/BRAMs and the downstream serial consumer and replaces file-driven byte streaming in synthesizable designs. It owns address generation, channel selection, a valid/ready handshake and frame markers (sof/eol/eof).

## Interface
- IMG_W, 64, pixels per row (>=1)
- IMG_H, 48, rows per frame (>=1)
- ADDR_W, 12, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin one frame; sampled only in IDLE
- rd_addr  out  ADDR_W  pixel address shared by all three memories
- rd_en  out  3  one-hot read strobe {B,G,R} = bits {2,1,0}
- rd_data_r, rd_data_g, rd_data_b  in  8 each  memory read data, valid exactly 1 cycle after rd_en
- out_data  out  8  stream byte
- out_chan  out  2  0=R, 1=G, 2=B for current out_data
- out_valid  out  1  out_data valid; held until accepted
- out_ready  in  1  consumer accepts when out_valid & out_ready
- sof  out  1  qualifies out_valid: R byte of pixel 0
- eol  out  1  qualifies out_valid: B byte of last column of each row
- eof  out  1  qualifies out_valid: B byte of last pixel
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse after final byte accepted

## Operation
- FSM states: IDLE, REQ, LAT, SEND, DONE.
- IDLE: start=1 -> clear col, row, addr, chan to 0; go REQ.
- REQ: rd_en[chan]=1 for exactly this cycle, rd_addr=addr; go LAT.
- LAT: at end of cycle latch rd_data of selected chan into out_data; latch sof/eol/eof flags; go SEND.
- SEND: out_valid=1; out_data, out_chan, markers stable until handshake. On handshake:
  - chan<2: chan+1, go REQ.
  - chan=2 and not last pixel: chan=0, addr+1; col+1, or col=0 and row+1 when col=IMG_W-1; go REQ.
  - chan=2 and last pixel (row=IMG_H-1, col=IMG_W-1): go DONE.
- DONE: done=1 for one cycle; go IDLE.
- Marker rules: sof = (addr=0 & chan=0); eol = (col=IMG_W-1 & chan=2); eof = (last pixel & chan=2). eof implies eol on the same byte.
- IMG_W=1: every B byte carries eol. IMG_W=IMG_H=1: three bytes; sof on first, eol+eof on third.
- rd_addr holds its value when rd_en=0; address is linear (row*IMG_W+col) and never wraps within a frame.
- start while busy (including DONE) is ignored; no queuing.
- out_ready while out_valid=0 has no effect.
- rst asserted at any time, including mid-frame: immediately IDLE, counters cleared, frame abandoned; no done pulse.

## Timing
- Reset values: rd_addr=0, rd_en=0, out_data=0, out_chan=0, out_valid=0, sof=eol=eof=0, busy=0, done=0.
- start sampled at edge N -> rd_en at N+1 (REQ), data latched at edge N+2, out_valid high from N+2 edge (cycle N+3).
- Per byte: 3 cycles minimum (REQ, LAT, SEND with ready=1); each extra cycle of out_ready=0 adds one.
- Frame with ready always high: 9*IMG_W*IMG_H cycles from first REQ to final handshake; done in the following cycle; busy drops the cycle after done.
- out_valid never deasserts without a handshake (except on rst); no combinational path from out_ready to out_valid/out_data.
- rd_data is sampled only in LAT; its value at other times is ignored.

## Test plan
- Reset: rst pulsed mid-cycle with no clock edge -> all outputs 0 immediately; busy=0.
- Full frame, IMG_W=4, IMG_H=2, memories R[a]=a, G[a]=0x40+a, B[a]=0x80+a, out_ready=1: 24 bytes 00,40,80,01,41,81,..07,47,87; sof on byte 0, eol on bytes 11 and 23, eof on byte 23 only; done one cycle after byte 23; rd_addr 0..7.
- Backpressure: out_ready=0 for 5 cycles during G byte of pixel 2 -> out_data=0x42, out_chan=1 held stable; no rd_en issued; stream resumes in order with no duplicate or drop.
- start during busy and in DONE -> ignored; exactly 24 bytes; a second start in IDLE replays from address 0 with sof.
- Reset mid-frame after 10 bytes -> out_valid=0, no done; subsequent start gives full 24-byte frame from sof.
- Degenerate IMG_W=1, IMG_H=1 -> 3 bytes; sof on first, eol and eof both on third; done follows.
